// File: rtl/pe_sequencer_if.sv
// PE-side bundle of the sequencer: issue strobe, operand vectors and the two
// result return paths from the PE pipeline.
interface pe_sequencer_if #(
  parameter int PE_ELEMENTS   = 4,
  parameter int DATA_LEN      = 32,
  parameter int PE_OPCODE_LEN = 4
);
  logic [PE_OPCODE_LEN-1:0]        pe_opcode;
  logic                            pe_op_valid;
  logic                            pe_ready;
  logic [PE_ELEMENTS*DATA_LEN-1:0] data_a;
  logic [PE_ELEMENTS*DATA_LEN-1:0] data_b;
  logic                            pe_s1_valid;
  logic [PE_ELEMENTS*DATA_LEN-1:0] pe_s1_data;
  logic                            pe_s2_valid;
  logic [DATA_LEN-1:0]             pe_s2_data;

  modport master (
    output pe_opcode, pe_op_valid, data_a, data_b,
    input  pe_ready, pe_s1_valid, pe_s1_data, pe_s2_valid, pe_s2_data
  );

  modport slave (
    input  pe_opcode, pe_op_valid, data_a, data_b,
    output pe_ready, pe_s1_valid, pe_s1_data, pe_s2_valid, pe_s2_data
  );
endinterface

// File: rtl/pe_sequencer.sv
// Instruction sequencer and operand/result buffer for the SIMD PE array:
// host-loaded program, FETCH/EXEC per instruction, single-level hardware loop.
module pe_sequencer #(
  parameter int PE_ELEMENTS   = 4,
  parameter int DATA_LEN      = 32,
  parameter int OPCODE_LEN    = 4,
  parameter int ADDR_LEN      = 8,
  parameter int INST_LEN      = 12,
  parameter int IMEM_DEPTH    = 512,
  parameter int DMEM_DEPTH    = 64,
  parameter int PE_OPCODE_LEN = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  input  logic                              host_we,
  input  logic [1:0]                        host_sel,
  input  logic [$clog2(IMEM_DEPTH)-1:0]     host_addr,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0]   host_wdata,
  input  logic [$clog2(DMEM_DEPTH)-1:0]     res_raddr,
  output logic [PE_ELEMENTS*DATA_LEN-1:0]   res_rdata,
  output logic [1:0]                        dbg_state,
  pe_sequencer_if.master                    pe
);
  localparam int V    = PE_ELEMENTS * DATA_LEN;
  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [OPCODE_LEN-1:0] OP_FETCH_A      = OPCODE_LEN'(1);
  localparam logic [OPCODE_LEN-1:0] OP_FETCH_B      = OPCODE_LEN'(2);
  localparam logic [OPCODE_LEN-1:0] OP_ADD          = OPCODE_LEN'(3);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_RESULT = OPCODE_LEN'(9);
  localparam logic [OPCODE_LEN-1:0] OP_STOP         = OPCODE_LEN'(10);
  localparam logic [OPCODE_LEN-1:0] OP_LOOP_SET     = OPCODE_LEN'(11);
  localparam logic [OPCODE_LEN-1:0] OP_LOOP_END     = OPCODE_LEN'(12);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2} state_t;
  state_t state_q, state_d;

  logic [INST_LEN-1:0] imem [IMEM_DEPTH];
  logic [V-1:0]        amem [DMEM_DEPTH];
  logic [V-1:0]        bmem [DMEM_DEPTH];
  logic [V-1:0]        rmem [DMEM_DEPTH];

  logic [INST_LEN-1:0]      ir;
  logic [IA_W-1:0]          pc_q, lstart_q;
  logic [ADDR_LEN-1:0]      lcnt_q;
  logic [V-1:0]             rbuf_q, data_a_q, data_b_q;
  logic [PE_OPCODE_LEN-1:0] pe_opcode_q;
  logic                     pe_op_valid_q;

  logic [OPCODE_LEN-1:0] opc;
  logic [ADDR_LEN-1:0]   operand;
  logic [DA_W-1:0]       dm_idx;
  logic                  op_in_range;
  logic is_pe_op, stall, act, do_fetch_a, do_fetch_b, do_issue, do_store;
  logic do_stop, do_lset, do_ljump, advance, overrun;

  assign opc         = ir[OPCODE_LEN-1:0];
  assign operand     = ir[OPCODE_LEN+ADDR_LEN-1:OPCODE_LEN];
  assign dm_idx      = operand[DA_W-1:0];
  assign op_in_range = 32'(operand) < DMEM_DEPTH;

  // PE handshake: pe_op_valid is a one-cycle strobe raised only after pe_ready
  // was seen high in EXEC; while pe_ready is low the instruction waits in EXEC
  // with no strobe, no memory write and no pc change.
  assign pe.pe_opcode   = pe_opcode_q;
  assign pe.pe_op_valid = pe_op_valid_q;
  assign pe.data_a      = data_a_q;
  assign pe.data_b      = data_b_q;
  assign dbg_state      = state_q;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (stall)                    state_d = S_EXEC;
        else if (do_stop || overrun)  state_d = S_IDLE;
        else                          state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_pe_op   = (opc >= OP_ADD) && (opc <= OP_STORE_RESULT);
    stall      = (state_q == S_EXEC) && is_pe_op && !pe.pe_ready;
    act        = (state_q == S_EXEC) && !stall;
    do_fetch_a = act && (opc == OP_FETCH_A) && op_in_range;
    do_fetch_b = act && (opc == OP_FETCH_B) && op_in_range;
    do_issue   = act && is_pe_op;
    do_store   = act && (opc == OP_STORE_RESULT) && op_in_range;
    do_stop    = act && (opc == OP_STOP);
    do_lset    = act && (opc == OP_LOOP_SET);
    do_ljump   = act && (opc == OP_LOOP_END) && (lcnt_q != '0);
    advance    = act && !do_stop && !do_ljump;
    // Advancing past the last instruction word means the program had no STOP.
    overrun    = advance && (pc_q == IA_W'(IMEM_DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      pe_op_valid_q <= 1'b0;
      pe_opcode_q   <= '0;
      data_a_q      <= '0;
      data_b_q      <= '0;
      res_rdata     <= '0;
      rbuf_q        <= '0;
      pc_q          <= '0;
      lstart_q      <= '0;
      lcnt_q        <= '0;
    end else begin
      done          <= 1'b0;
      pe_op_valid_q <= 1'b0;
      res_rdata     <= rmem[res_raddr];

      if (pe.pe_s1_valid)      rbuf_q <= pe.pe_s1_data;
      else if (pe.pe_s2_valid) rbuf_q <= {rbuf_q[V-DATA_LEN-1:0], pe.pe_s2_data};

      if (state_q == S_IDLE && start) begin
        pc_q <= '0;
        err  <= 1'b0;
        busy <= 1'b1;
      end

      if (do_fetch_a) data_a_q <= amem[dm_idx];
      if (do_fetch_b) data_b_q <= bmem[dm_idx];

      if (do_issue) begin
        pe_opcode_q   <= PE_OPCODE_LEN'(opc - OPCODE_LEN'(2));
        pe_op_valid_q <= 1'b1;
      end

      if (do_stop) begin
        pe_opcode_q <= PE_OPCODE_LEN'(8);
        done        <= 1'b1;
        busy        <= 1'b0;
      end

      if (do_lset) begin
        lcnt_q   <= operand;
        lstart_q <= pc_q + IA_W'(1);
      end

      if (do_ljump) begin
        lcnt_q <= lcnt_q - ADDR_LEN'(1);
        pc_q   <= lstart_q;
      end

      if (advance) pc_q <= pc_q + IA_W'(1);

      if (overrun) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

  // Memories keep their contents across reset; writes are suppressed while
  // rstn is low so an aborted run leaves no partial store behind.
  always_ff @(posedge clk) begin
    if (rstn && host_we && !busy) begin
      case (host_sel)
        2'd0: if (32'(host_addr) < IMEM_DEPTH) imem[host_addr] <= host_wdata[INST_LEN-1:0];
        2'd1: if (32'(host_addr) < DMEM_DEPTH) amem[host_addr[DA_W-1:0]] <= host_wdata;
        2'd2: if (32'(host_addr) < DMEM_DEPTH) bmem[host_addr[DA_W-1:0]] <= host_wdata;
        default: ;
      endcase
    end
    if (rstn && do_store) rmem[dm_idx] <= rbuf_q;
    if (state_q == S_FETCH) ir <= imem[pc_q];
  end
endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: a PE model answers ADD, a scoreboard checks
// every issue strobe and every result read against hand-computed expectations.
module tb_pe_sequencer;
  localparam int V    = 128;
  localparam int IA_W = 9;
  localparam int DA_W = 6;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, err;
  logic            host_we = 1'b0;
  logic [1:0]      host_sel = 2'd0;
  logic [IA_W-1:0] host_addr = '0;
  logic [V-1:0]    host_wdata = '0;
  logic [DA_W-1:0] res_raddr = '0;
  logic [V-1:0]    res_rdata;
  logic [1:0]      dbg_state;

  logic            pe_ready = 1'b1;
  logic            m_s1_valid = 1'b0, d_s1_valid = 1'b0, d_s2_valid = 1'b0;
  logic [V-1:0]    m_s1_data = '0, d_s1_data = '0;
  logic [31:0]     d_s2_data = '0;

  pe_sequencer_if #(.PE_ELEMENTS(4), .DATA_LEN(32), .PE_OPCODE_LEN(4)) pif ();

  assign pif.pe_ready    = pe_ready;
  assign pif.pe_s1_valid = m_s1_valid | d_s1_valid;
  assign pif.pe_s1_data  = m_s1_valid ? m_s1_data : d_s1_data;
  assign pif.pe_s2_valid = d_s2_valid;
  assign pif.pe_s2_data  = d_s2_data;

  pe_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err(err),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
    .res_raddr(res_raddr), .res_rdata(res_rdata), .dbg_state(dbg_state), .pe(pif)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int t_start  = 0;
  bit mon_en   = 1'b1;
  logic rd_req = 1'b0, rd_pend_q = 1'b0;
  logic [3:0]   exp_op_q[$];
  logic [V-1:0] exp_q[$];
  logic [11:0]  prog[$];

  always @(posedge clk) rd_pend_q <= rd_req;

  function automatic logic [V-1:0] vec4(input int l3, input int l2, input int l1, input int l0);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  function automatic logic [11:0] ins(input int opc, input int opd);
    return {8'(opd), 4'(opc)};
  endfunction

  task automatic check(input string name, input logic [V-1:0] got, input logic [V-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // ---------------- PE model: ADD returns lane-wise a+b on stage 1 ----------------
  always @(negedge clk) begin
    m_s1_valid = 1'b0;
    if (rstn && pif.pe_op_valid && pif.pe_opcode == 4'd1) begin
      for (int l = 0; l < 4; l++)
        m_s1_data[l*32 +: 32] = pif.data_a[l*32 +: 32] + pif.data_b[l*32 +: 32];
      m_s1_valid = 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [3:0]   e_op;
    logic [V-1:0] e_res;
    if (rstn && mon_en && pif.pe_op_valid) begin
      n_checks++;
      if (exp_op_q.size() == 0) begin
        n_fail++;
        $display("FAIL pe_strobe: got opcode %0d, want no strobe", pif.pe_opcode);
      end else begin
        e_op = exp_op_q.pop_front();
        if (pif.pe_opcode !== e_op) begin
          n_fail++;
          $display("FAIL pe_opcode: got %0d, want %0d", pif.pe_opcode, e_op);
        end
      end
    end
    if (rd_pend_q) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL res_read: got %0h, want nothing queued", res_rdata);
      end else begin
        e_res = exp_q.pop_front();
        if (res_rdata !== e_res) begin
          n_fail++;
          $display("FAIL res_rdata: got %0h, want %0h", res_rdata, e_res);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [1:0] sel, input int addr, input logic [V-1:0] data);
    @(negedge clk);
    host_we = 1'b1; host_sel = sel; host_addr = IA_W'(addr); host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) host_write(2'd0, i, V'(prog[i]));
  endtask

  task automatic start_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; t_start = cyc;
    check("busy_rise", V'(busy), V'(1));
  endtask

  task automatic finish_prog(input int budget, input int exp_cyc, input string tag);
    int n = 0;
    while (!(done || err) && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done"}, V'(done), V'(1));
    check({tag, "_err"}, V'(err), V'(0));
    check({tag, "_cycles"}, V'(cyc - t_start), V'(exp_cyc));
    @(negedge clk);
    check({tag, "_done_pulse"}, V'(done), V'(0));
    check({tag, "_busy_low"}, V'(busy), V'(0));
  endtask

  task automatic read_res(input int addr, input logic [V-1:0] want);
    @(negedge clk);
    res_raddr = DA_W'(addr); rd_req = 1'b1; exp_q.push_back(want);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic s_pulse(input bit s1v, input logic [V-1:0] s1d, input bit s2v, input int s2d);
    @(negedge clk);
    d_s1_valid = s1v; d_s1_data = s1d; d_s2_valid = s2v; d_s2_data = 32'(s2d);
    @(negedge clk);
    d_s1_valid = 1'b0; d_s2_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", V'(busy), V'(0));
    check("rst_done", V'(done), V'(0));
    check("rst_err", V'(err), V'(0));
    check("rst_valid", V'(pif.pe_op_valid), V'(0));
    check("rst_opcode", V'(pif.pe_opcode), V'(0));
    check("rst_data_a", pif.data_a, '0);
    check("rst_rdata", res_rdata, '0);
    check("rst_state", V'(dbg_state), V'(0));
    rstn = 1'b1;

    host_write(2'd1, 3, vec4(1, 2, 3, 4));
    host_write(2'd2, 5, vec4(10, 20, 30, 40));
    host_write(2'd2, 36, vec4(3, 3, 3, 3));
    host_write(2'd2, 100, vec4(7, 7, 7, 7));

    // Basic FETCH_A / FETCH_B / ADD / STORE_RESULT / STOP
    prog = {ins(1, 3), ins(2, 5), ins(3, 0), ins(9, 7), ins(10, 0)};
    load_prog();
    exp_op_q.push_back(4'd1); exp_op_q.push_back(4'd7);
    start_prog();
    finish_prog(100, 10, "t1");
    check("t1_stop_opcode", V'(pif.pe_opcode), V'(8));
    check("t1_data_a", pif.data_a, vec4(1, 2, 3, 4));
    check("t1_data_b", pif.data_b, vec4(10, 20, 30, 40));
    check("t1_ops_drained", V'(exp_op_q.size()), V'(0));
    read_res(7, vec4(11, 22, 33, 44));

    // Same program, PE back-pressure for 5 cycles on ADD
    pe_ready = 1'b0;
    exp_op_q.push_back(4'd1); exp_op_q.push_back(4'd7);
    start_prog();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 5 && i <= 9) begin
        check("t2_stall_valid", V'(pif.pe_op_valid), V'(0));
        check("t2_stall_state", V'(dbg_state), V'(2));
      end
    end
    pe_ready = 1'b1;
    finish_prog(100, 15, "t2");
    check("t2_ops_drained", V'(exp_op_q.size()), V'(0));
    read_res(7, vec4(11, 22, 33, 44));

    // Hardware loop: 3 iterations of STORE_TEMP_S2
    prog = {ins(11, 2), ins(8, 0), ins(12, 0), ins(10, 0)};
    load_prog();
    repeat (3) exp_op_q.push_back(4'd6);
    start_prog();
    finish_prog(100, 16, "t3");
    check("t3_ops_drained", V'(exp_op_q.size()), V'(0));

    // Result buffer: s1 zeros then s2 shifts 5,6,7,8
    s_pulse(1'b1, '0, 1'b0, 0);
    s_pulse(1'b0, '0, 1'b1, 5);
    s_pulse(1'b0, '0, 1'b1, 6);
    s_pulse(1'b0, '0, 1'b1, 7);
    s_pulse(1'b0, '0, 1'b1, 8);
    prog = {ins(9, 9), ins(10, 0)};
    load_prog();
    exp_op_q.push_back(4'd7);
    start_prog();
    finish_prog(50, 4, "t4a");
    read_res(9, vec4(5, 6, 7, 8));

    // Simultaneous s1/s2: s1 wins
    s_pulse(1'b1, vec4(100, 200, 300, 400), 1'b1, 99);
    prog = {ins(9, 10), ins(9, 0), ins(10, 0)};
    load_prog();
    exp_op_q.push_back(4'd7); exp_op_q.push_back(4'd7);
    start_prog();
    finish_prog(50, 6, "t4b");
    read_res(10, vec4(100, 200, 300, 400));
    read_res(0, vec4(100, 200, 300, 400));

    // Overrun: whole memory of NOOP-class opcodes, no STOP
    for (int i = 0; i < 512; i++) host_write(2'd0, i, V'(ins((i % 4 == 0) ? 0 : 12 + (i % 4), i)));
    start_prog();
    n = 0;
    while (!(done || err) && n < 1100) begin @(negedge clk); n++; end
    check("t5_err_set", V'(err), V'(1));
    check("t5_no_done", V'(done), V'(0));
    check("t5_cycles", V'(cyc - t_start), V'(1024));
    @(negedge clk);
    check("t5_busy_low", V'(busy), V'(0));
    check("t5_err_sticky", V'(err), V'(1));
    check("t5_state_idle", V'(dbg_state), V'(0));
    host_write(2'd0, 0, V'(ins(10, 0)));
    start_prog();
    check("t5_err_cleared", V'(err), V'(0));
    finish_prog(20, 2, "t5b");

    // Busy-time host writes ignored, out-of-range operands, high host address
    s_pulse(1'b0, '0, 1'b1, 1);
    prog = {ins(11, 3), ins(7, 0), ins(12, 0), ins(1, 3), ins(2, 36), ins(2, 64), ins(9, 64), ins(10, 0)};
    load_prog();
    repeat (4) exp_op_q.push_back(4'd5);
    exp_op_q.push_back(4'd7);
    start_prog();
    host_write(2'd1, 3, vec4(13, 13, 13, 13));
    host_write(2'd0, 7, V'(ins(0, 0)));
    finish_prog(200, 28, "t6a");
    check("t6a_data_a", pif.data_a, vec4(1, 2, 3, 4));
    check("t6a_data_b", pif.data_b, vec4(3, 3, 3, 3));
    check("t6a_ops_drained", V'(exp_op_q.size()), V'(0));
    read_res(0, vec4(100, 200, 300, 400));

    // Reset in the middle of a long loop
    prog = {ins(11, 200), ins(8, 0), ins(12, 0), ins(10, 0)};
    load_prog();
    mon_en = 1'b0;
    start_prog();
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("t6b_busy", V'(busy), V'(0));
    check("t6b_done", V'(done), V'(0));
    check("t6b_valid", V'(pif.pe_op_valid), V'(0));
    check("t6b_opcode", V'(pif.pe_opcode), V'(0));
    check("t6b_data_a", pif.data_a, '0);
    check("t6b_data_b", pif.data_b, '0);
    check("t6b_state", V'(dbg_state), V'(0));
    rstn = 1'b1;
    mon_en = 1'b1;
    read_res(7, vec4(11, 22, 33, 44));
    prog = {ins(9, 11), ins(10, 0)};
    load_prog();
    exp_op_q.push_back(4'd7);
    start_prog();
    finish_prog(50, 4, "t6c");
    read_res(11, '0);

    repeat (3) @(negedge clk);
    check("final_ops_drained", V'(exp_op_q.size()), V'(0));
    check("final_reads_drained", V'(exp_q.size()), V'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by time %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
